// File: rtl/uart_tx_dma.sv
// Byte-stream DMA for the UART transmit path: fetches words over a Wishbone master,
// polls TX_FIFO_FULL and writes each byte to the UART TX register.
module uart_tx_dma #(
   parameter logic [31:0] UART_BASE  = 32'h4000_0000,
   parameter int unsigned LEN_BITS   = 16,
   parameter int unsigned POLL_DELAY = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_cyc_i,
   input  logic        cfg_stb_i,
   input  logic        cfg_we_i,
   input  logic [31:0] cfg_addr_i,
   input  logic [31:0] cfg_data_i,
   output logic [31:0] cfg_data_o,
   output logic        cfg_ack_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   output logic        m_we_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_data_o,
   input  logic [31:0] m_data_i,
   input  logic        m_ack_i,
   output logic        irq_o
);

   localparam int unsigned CW = $clog2(POLL_DELAY + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_POLL, S_BACKOFF, S_WRITE, S_NEXT, S_DONE
   } state_t;

   state_t              state;
   logic [31:0]         src_addr;
   logic [LEN_BITS-1:0] len_reg;
   logic [LEN_BITS-1:0] remaining;
   logic [31:0]         cur_addr;
   logic [31:0]         word_buf;
   logic [CW-1:0]       backoff_cnt;
   logic                irq_en, busy, done, aborted;
   logic                start_pend, abort_req;

   logic        cfg_req, cfg_wr, ctrl_wr, stat_wr;
   logic [1:0]  cfg_sel;
   logic [31:0] cfg_rdata;
   logic [15:0] rem16;
   logic [7:0]  tx_byte;
   logic        req_we;
   logic [31:0] req_addr, req_data;
   logic        cfg_addr_unused;

   assign cfg_sel         = cfg_addr_i[3:2];
   assign cfg_req         = cfg_cyc_i & cfg_stb_i & ~cfg_ack_o;
   assign cfg_wr          = cfg_req & cfg_we_i;
   assign ctrl_wr         = cfg_wr && (cfg_sel == 2'b10);
   assign stat_wr         = cfg_wr && (cfg_sel == 2'b11);
   assign rem16           = 16'(remaining);
   assign tx_byte         = word_buf[{cur_addr[1:0], 3'b000} +: 8];
   assign irq_o           = done & irq_en;
   assign cfg_addr_unused = ^{cfg_addr_i[31:4], cfg_addr_i[1:0]};

   always_comb begin
      cfg_rdata = '0;
      unique case (cfg_sel)
         2'b00:   cfg_rdata = src_addr;
         2'b01:   cfg_rdata = 32'(len_reg);
         2'b10:   cfg_rdata = {29'b0, irq_en, 2'b00};
         default: cfg_rdata = {rem16, 13'b0, aborted, done, busy};
      endcase
   end

   // BACKOFF issues the next poll directly, so it shares the POLL request.
   always_comb begin
      req_we   = 1'b0;
      req_addr = UART_BASE + 32'h10;
      req_data = '0;
      if (state == S_FETCH) begin
         req_addr = {cur_addr[31:2], 2'b00};
      end else if (state == S_WRITE) begin
         req_we   = 1'b1;
         req_addr = UART_BASE;
         req_data = {24'b0, tx_byte};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ack_o  <= 1'b0;
         cfg_data_o <= '0;
         src_addr   <= '0;
         len_reg    <= '0;
         irq_en     <= 1'b0;
      end else begin
         cfg_ack_o <= cfg_cyc_i & cfg_stb_i & ~cfg_ack_o;
         if (cfg_req) cfg_data_o <= cfg_we_i ? '0 : cfg_rdata;
         if (cfg_wr) begin
            unique case (cfg_sel)
               2'b00:   if (!busy) src_addr <= cfg_data_i;
               2'b01:   if (!busy) len_reg <= cfg_data_i[LEN_BITS-1:0];
               2'b10:   irq_en <= cfg_data_i[2];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         remaining   <= '0;
         cur_addr    <= '0;
         word_buf    <= '0;
         backoff_cnt <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         start_pend  <= 1'b0;
         abort_req   <= 1'b0;
         m_cyc_o     <= 1'b0;
         m_stb_o     <= 1'b0;
         m_we_o      <= 1'b0;
         m_addr_o    <= '0;
         m_data_o    <= '0;
      end else begin
         start_pend <= ctrl_wr & cfg_data_i[0];
         if (ctrl_wr && cfg_data_i[1] && busy) abort_req <= 1'b1;
         if (stat_wr && cfg_data_i[1]) done <= 1'b0;
         if (stat_wr && cfg_data_i[2]) aborted <= 1'b0;

         unique case (state)
            S_IDLE: begin
               abort_req <= 1'b0;
               if (start_pend) begin
                  if (len_reg == '0) begin
                     done <= 1'b1;
                  end else begin
                     cur_addr  <= src_addr;
                     remaining <= len_reg;
                     busy      <= 1'b1;
                     done      <= 1'b0;
                     aborted   <= 1'b0;
                     state     <= S_FETCH;
                  end
               end
            end
            // Abort is only honoured between transactions so a bus cycle is never cut short.
            S_FETCH, S_POLL, S_WRITE: begin
               if (!m_cyc_o) begin
                  if (abort_req) begin
                     busy      <= 1'b0;
                     aborted   <= 1'b1;
                     abort_req <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     m_cyc_o  <= 1'b1;
                     m_stb_o  <= 1'b1;
                     m_we_o   <= req_we;
                     m_addr_o <= req_addr;
                     m_data_o <= req_data;
                  end
               end else if (m_ack_i) begin
                  m_cyc_o <= 1'b0;
                  m_stb_o <= 1'b0;
                  if (state == S_FETCH) begin
                     word_buf <= m_data_i;
                     state    <= S_POLL;
                  end else if (state == S_POLL) begin
                     if (m_data_i[0]) begin
                        backoff_cnt <= CW'(POLL_DELAY - 1);
                        state       <= S_BACKOFF;
                     end else begin
                        state <= S_WRITE;
                     end
                  end else begin
                     cur_addr  <= cur_addr + 32'd1;
                     remaining <= remaining - LEN_BITS'(1);
                     state     <= S_NEXT;
                  end
               end
            end
            S_BACKOFF: begin
               if (abort_req) begin
                  busy      <= 1'b0;
                  aborted   <= 1'b1;
                  abort_req <= 1'b0;
                  state     <= S_IDLE;
               end else if (backoff_cnt == '0) begin
                  m_cyc_o  <= 1'b1;
                  m_stb_o  <= 1'b1;
                  m_we_o   <= req_we;
                  m_addr_o <= req_addr;
                  m_data_o <= req_data;
                  state    <= S_POLL;
               end else begin
                  backoff_cnt <= backoff_cnt - CW'(1);
               end
            end
            S_NEXT: begin
               if (abort_req) begin
                  busy      <= 1'b0;
                  aborted   <= 1'b1;
                  abort_req <= 1'b0;
                  state     <= S_IDLE;
               end else if (remaining == '0) begin
                  state <= S_DONE;
               end else if (cur_addr[1:0] == 2'b00) begin
                  state <= S_FETCH;
               end else begin
                  state <= S_POLL;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_dma.sv
// Scoreboard bench for uart_tx_dma: a memory/UART slave model answers the master port,
// a monitor compares every acked transaction and every checked config read.
module tb_uart_tx_dma;

   localparam logic [31:0] TX_A   = 32'h4000_0000;
   localparam logic [31:0] POLL_A = 32'h4000_0010;
   localparam int          PD     = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_cyc_i = 1'b0, cfg_stb_i = 1'b0, cfg_we_i = 1'b0;
   logic [31:0] cfg_addr_i = '0, cfg_data_i = '0;
   logic [31:0] cfg_data_o;
   logic        cfg_ack_o;
   logic        m_cyc_o, m_stb_o, m_we_o;
   logic [31:0] m_addr_o, m_data_o;
   logic [31:0] m_data_i = '0;
   logic        m_ack_i = 1'b0;
   logic        irq_o;

   always #5 clk = ~clk;

   uart_tx_dma #(.UART_BASE(32'h4000_0000), .LEN_BITS(16), .POLL_DELAY(PD)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_cyc_i(cfg_cyc_i), .cfg_stb_i(cfg_stb_i), .cfg_we_i(cfg_we_i),
      .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
      .cfg_data_o(cfg_data_o), .cfg_ack_o(cfg_ack_o),
      .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
      .m_addr_o(m_addr_o), .m_data_o(m_data_o),
      .m_data_i(m_data_i), .m_ack_i(m_ack_i), .irq_o(irq_o)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t        exp_q[$];
   logic [31:0] cfg_exp_q[$];
   logic        poll_q[$];
   logic [31:0] mem [bit [31:0]];
   int          checks = 0;
   int          errors = 0;
   int          rd_delay = 0, wr_delay = 0, wcnt = 0;
   int          gap = 0;
   logic        last_busy = 1'b0;
   logic        rd_chk = 1'b0;
   logic        cyc_seen = 1'b0;
   logic        irq_at_ack = 1'b0;
   logic [31:0] rd;

   task automatic push_rd(input logic [31:0] a);
      exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
   endtask

   task automatic push_wr(input logic [7:0] b);
      exp_q.push_back('{we: 1'b1, addr: TX_A, data: {24'h0, b}});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic cfg_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rdata);
      logic ok;
      ok = 1'b0;
      cfg_cyc_i = 1'b1; cfg_stb_i = 1'b1; cfg_we_i = we; cfg_addr_i = a; cfg_data_i = d;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (cfg_ack_o) begin ok = 1'b1; break; end
      end
      rdata = cfg_data_o;
      irq_at_ack = irq_o;
      if (!ok) timeout("cfg_ack");
      @(posedge clk); #1;
      cfg_cyc_i = 1'b0; cfg_stb_i = 1'b0; cfg_we_i = 1'b0;
   endtask

   task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] unused_rd;
      cfg_xfer(1'b1, a, d, unused_rd);
   endtask

   task automatic cfg_rd_chk(input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] unused_rd;
      cfg_exp_q.push_back(exp);
      rd_chk = 1'b1;
      cfg_xfer(1'b0, a, 32'h0, unused_rd);
      rd_chk = 1'b0;
   endtask

   task automatic wait_done(input string name);
      logic [31:0] s;
      logic        ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cfg_xfer(1'b0, 32'hC, 32'h0, s);
         if (s[1]) begin ok = 1'b1; break; end
      end
      if (!ok) timeout(name);
   endtask

   task automatic wait_idle(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_cyc_o) begin ok = 1'b1; break; end
      end
      if (!ok) timeout(name);
   endtask

   // Slave model: acks after a programmable delay, returns memory words or queued poll status.
   always @(posedge clk) begin
      #2;
      if (m_ack_i) begin
         m_ack_i = 1'b0;
         wcnt = 0;
      end else if (m_cyc_o && m_stb_o) begin
         if (wcnt >= (m_we_o ? wr_delay : rd_delay)) begin
            m_ack_i = 1'b1;
            if (m_we_o)                   m_data_i = 32'h0;
            else if (m_addr_o == POLL_A)  m_data_i = (poll_q.size() != 0) ? {31'h0, poll_q.pop_front()} : 32'h0;
            else if (mem.exists(m_addr_o)) m_data_i = mem[m_addr_o];
            else                          m_data_i = 32'h0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   always @(negedge clk) begin
      txn_t e;
      if (m_cyc_o) cyc_seen = 1'b1;
      if (m_cyc_o && m_stb_o && m_ack_i) begin
         if (!m_we_o && m_addr_o == POLL_A && last_busy) begin
            checks++;
            if (gap != PD) begin
               errors++;
               $display("FAIL backoff_gap: got %0d idle cycles expected %0d", gap, PD);
            end
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_txn: we=%b addr=%h data=%h expected none", m_we_o, m_addr_o, m_data_o);
         end else begin
            e = exp_q.pop_front();
            if ({m_we_o, m_addr_o, (m_we_o ? m_data_o : 32'h0)} !== e) begin
               errors++;
               $display("FAIL txn: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                        m_we_o, m_addr_o, m_data_o, e.we, e.addr, e.data);
            end
         end
         last_busy = !m_we_o && (m_addr_o == POLL_A) && m_data_i[0];
         gap = 0;
      end else if (!m_stb_o) begin
         gap++;
      end
      if (cfg_ack_o && rd_chk) begin
         checks++;
         if (cfg_exp_q.size() == 0) begin
            errors++;
            $display("FAIL cfg_read: got %h expected none", cfg_data_o);
         end else begin
            rd = cfg_exp_q.pop_front();
            if (cfg_data_o !== rd) begin
               errors++;
               $display("FAIL cfg_read addr %h: got %h expected %h", cfg_addr_i, cfg_data_o, rd);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {m_cyc_o, m_stb_o, m_we_o, cfg_ack_o, irq_o}, 32'h0);
      chk("reset_m_addr", m_addr_o, 32'h0);
      chk("reset_cfg_data", cfg_data_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cfg_rd_chk(32'h0, 32'h0);
      cfg_rd_chk(32'h4, 32'h0);
      cfg_rd_chk(32'h8, 32'h0);
      cfg_rd_chk(32'hC, 32'h0);

      // Five bytes across two words, interrupts enabled.
      mem[32'h100] = 32'h4433_2211;
      mem[32'h104] = 32'h0000_0055;
      cfg_wr(32'h0, 32'h100);
      cfg_wr(32'h4, 32'd5);
      push_rd(32'h100);
      push_rd(POLL_A); push_wr(8'h11);
      push_rd(POLL_A); push_wr(8'h22);
      push_rd(POLL_A); push_wr(8'h33);
      push_rd(POLL_A); push_wr(8'h44);
      push_rd(32'h104);
      push_rd(POLL_A); push_wr(8'h55);
      cfg_wr(32'h8, 32'h5);
      wait_done("t1_done");
      chk("t1_drained", exp_q.size(), 0);
      chk("t1_irq", irq_o, 1);
      cfg_rd_chk(32'hC, 32'h0000_0002);
      cfg_rd_chk(32'h8, 32'h0000_0004);
      cfg_wr(32'hC, 32'h2);
      chk("t1_irq_clear", irq_o, 0);

      // Unaligned source: byte 3 of one word, then byte 0 of the next.
      cfg_wr(32'h0, 32'h103);
      cfg_wr(32'h4, 32'd2);
      push_rd(32'h100);
      push_rd(POLL_A); push_wr(8'h44);
      push_rd(32'h104);
      push_rd(POLL_A); push_wr(8'h55);
      cfg_wr(32'h8, 32'h1);
      wait_done("t2_done");
      chk("t2_drained", exp_q.size(), 0);
      chk("t2_irq_masked", irq_o, 0);
      cfg_rd_chk(32'hC, 32'h0000_0002);
      cfg_wr(32'hC, 32'h2);

      // Zero length: done one cycle after the CTRL ack, no bus activity.
      cfg_wr(32'h4, 32'd0);
      cyc_seen = 1'b0;
      cfg_wr(32'h8, 32'h5);
      chk("t3_irq_at_ack", irq_at_ack, 0);
      chk("t3_irq_next", irq_o, 1);
      repeat (10) @(negedge clk);
      chk("t3_no_cyc", cyc_seen, 0);
      cfg_rd_chk(32'hC, 32'h0000_0002);
      cfg_wr(32'hC, 32'h2);

      // TX FIFO full three times before accepting the byte.
      mem[32'h200] = 32'h0000_00A5;
      poll_q.push_back(1'b1); poll_q.push_back(1'b1); poll_q.push_back(1'b1); poll_q.push_back(1'b0);
      cfg_wr(32'h0, 32'h200);
      cfg_wr(32'h4, 32'd1);
      push_rd(32'h200);
      push_rd(POLL_A); push_rd(POLL_A); push_rd(POLL_A); push_rd(POLL_A);
      push_wr(8'hA5);
      cfg_wr(32'h8, 32'h1);
      wait_done("t4_done");
      chk("t4_drained", exp_q.size(), 0);
      cfg_rd_chk(32'hC, 32'h0000_0002);
      cfg_wr(32'hC, 32'h2);

      // Abort during a slow fetch, then restart.
      mem[32'h300] = 32'h00CC_BBAA;
      cfg_wr(32'h0, 32'h300);
      cfg_wr(32'h4, 32'd3);
      rd_delay = 5;
      push_rd(32'h300);
      cfg_wr(32'h8, 32'h1);
      begin
         logic ok;
         ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_cyc_o) begin ok = 1'b1; break; end
         end
         if (!ok) timeout("t5_fetch_start");
      end
      cfg_wr(32'h8, 32'h2);
      chk("t5_cyc_held", m_cyc_o, 1);
      wait_idle("t5_idle");
      rd_delay = 0;
      repeat (3) @(negedge clk);
      cfg_rd_chk(32'hC, 32'h0003_0004);
      push_rd(32'h300);
      push_rd(POLL_A); push_wr(8'hAA);
      push_rd(POLL_A); push_wr(8'hBB);
      push_rd(POLL_A); push_wr(8'hCC);
      cfg_wr(32'h8, 32'h5);
      wait_done("t5_restart_done");
      chk("t5_drained", exp_q.size(), 0);
      cfg_rd_chk(32'hC, 32'h0000_0002);
      chk("t5_irq", irq_o, 1);
      cfg_wr(32'hC, 32'h2);

      // Asynchronous reset while a write waits for ack and a config ack is high.
      mem[32'h400] = 32'h0000_1234;
      cfg_wr(32'h0, 32'h400);
      cfg_wr(32'h4, 32'd2);
      wr_delay = 20;
      push_rd(32'h400);
      push_rd(POLL_A);
      cfg_wr(32'h8, 32'h5);
      begin
         logic ok;
         ok = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_cyc_o && m_we_o) begin ok = 1'b1; break; end
         end
         if (!ok) timeout("t6_write_start");
      end
      cfg_cyc_i = 1'b1; cfg_stb_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = 32'hC;
      @(posedge clk); #1;
      chk("t6_ack_before_rst", cfg_ack_o, 1);
      chk("t6_cyc_before_rst", m_cyc_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_m_cyc", m_cyc_o, 0);
      chk("t6_rst_m_stb", m_stb_o, 0);
      chk("t6_rst_irq", irq_o, 0);
      chk("t6_rst_cfg_ack", cfg_ack_o, 0);
      cfg_cyc_i = 1'b0; cfg_stb_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wr_delay = 0;
      @(posedge clk); #1;
      chk("t6_drained", exp_q.size(), 0);
      cfg_rd_chk(32'hC, 32'h0);
      cfg_rd_chk(32'h0, 32'h0);
      cfg_rd_chk(32'h4, 32'h0);
      cfg_rd_chk(32'h8, 32'h0);
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
